// File: rtl/mem_sched_pkg.sv
// Shared types and helpers for the burst-granular memory port scheduler.
package mem_sched_pkg;

    // IDLE: arbitrate and grant; BURST: stream beats of the granted burst.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } sched_state_e;

    // Address step between consecutive beats of a burst.
    function automatic int beat_bytes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority pick: the search starts one past the previous owner and
// wraps modulo N, so the most recent owner has the lowest priority.
module rr_pick #(
    parameter int NUM_REQUESTERS = 4,
    parameter int ID_W           = $clog2(NUM_REQUESTERS)
) (
    input  logic [NUM_REQUESTERS-1:0] i_req,
    input  logic [ID_W-1:0]           i_last_id,
    output logic                      o_found,
    output logic [ID_W-1:0]           o_id
);

    int idx;

    // First requester found walking upward from last_id+1; earlier hits win.
    always_comb begin
        o_found = 1'b0;
        o_id    = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQUESTERS; k++) begin
            idx = (int'(i_last_id) + k) % NUM_REQUESTERS;
            if (!o_found && i_req[idx]) begin
                o_found = 1'b1;
                o_id    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_port_scheduler.sv
// Shares one beat-per-cycle memory request port among NUM_REQUESTERS burst
// clients. Ownership is held for a whole burst; priority rotates past the
// owner once its last beat is accepted.
module mem_port_scheduler
    import mem_sched_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int LEN_W          = 4,
    parameter int ID_W           = $clog2(NUM_REQUESTERS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQUESTERS-1:0]        i_req_valid,
    input  logic [NUM_REQUESTERS*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQUESTERS*LEN_W-1:0]  i_req_len,
    input  logic [NUM_REQUESTERS-1:0]        i_req_we,
    output logic [NUM_REQUESTERS-1:0]        o_req_done,
    output logic                             o_mem_valid,
    output logic [ADDR_W-1:0]                o_mem_addr,
    output logic                             o_mem_we,
    output logic                             o_mem_last,
    output logic [ID_W-1:0]                  o_mem_id,
    input  logic                             i_mem_ready
);

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(beat_bytes(DATA_W));
    localparam logic [ID_W-1:0]   LAST_INIT = ID_W'(NUM_REQUESTERS - 1);

    sched_state_e      state_q, state_d;
    logic [ID_W-1:0]   last_id_q, last_id_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              we_q, we_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;

    logic              pick_found;
    logic [ID_W-1:0]   pick_id;
    logic              beat_xfer;
    logic              beat_last;

    rr_pick #(
        .NUM_REQUESTERS(NUM_REQUESTERS),
        .ID_W          (ID_W)
    ) u_rr_pick (
        .i_req    (i_req_valid),
        .i_last_id(last_id_q),
        .o_found  (pick_found),
        .o_id     (pick_id)
    );

    assign beat_last = (cnt_q == len_q);
    assign beat_xfer = (state_q == BURST) && i_mem_ready;

    // State and descriptor registers; reset drops any burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_id_q <= LAST_INIT;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_id_q <= last_id_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next state: grant from IDLE, return to IDLE after the last accepted beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_found) state_d = BURST;
            BURST:   if (beat_xfer && beat_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Descriptor latch at grant, then per-beat counter and address advance.
    always_comb begin
        last_id_d = last_id_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        we_d      = we_q;
        cnt_d     = cnt_q;
        if (state_q == IDLE) begin
            if (pick_found) begin
                id_d   = pick_id;
                addr_d = i_req_addr[pick_id*ADDR_W +: ADDR_W];
                len_d  = i_req_len[pick_id*LEN_W +: LEN_W];
                we_d   = i_req_we[pick_id];
                cnt_d  = '0;
            end
        end else if (beat_xfer) begin
            // Address wraps silently modulo 2^ADDR_W.
            addr_d = addr_q + ADDR_STEP;
            cnt_d  = cnt_q + LEN_W'(1);
            if (beat_last) last_id_d = id_q;
        end
    end

    // Outputs: all zero in IDLE; beat fields straight from registers in BURST.
    always_comb begin
        o_mem_valid = 1'b0;
        o_mem_addr  = '0;
        o_mem_we    = 1'b0;
        o_mem_last  = 1'b0;
        o_mem_id    = '0;
        o_req_done  = '0;
        if (state_q == BURST) begin
            o_mem_valid = 1'b1;
            o_mem_addr  = addr_q;
            o_mem_we    = we_q;
            o_mem_last  = beat_last;
            o_mem_id    = id_q;
            if (beat_xfer && beat_last) o_req_done[id_q] = 1'b1;
        end
    end

endmodule
